// File: rtl/frame_swap_ctrl.sv
// frame_swap_ctrl: double-buffer swap sequencer that flips the front buffer on vsync once the back frame is rendered
module frame_swap_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk_sys,
    input  logic             srst,
    input  logic             en,
    input  logic             vsync_async,
    input  logic             render_done,
    output logic             front_sel,
    output logic             swap_tick,
    output logic             render_start,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic             proto_err
);
    typedef enum logic [2:0] {IDLE, RENDER, WAIT_VBL, SWAP, SETTLE} state_t;
    state_t r_state, w_next;
    logic r_s1, r_s2, r_s3, r_vld, r_arm;
    logic [7:0] r_settle;
    logic w_vs_rise, w_start, w_miss;

    assign w_vs_rise = r_s2 & ~r_s3 & r_arm;

    // Synchronize vsync; edges count only after vsync has been observed low since reset
    always_ff @(posedge clk_sys or posedge srst) begin
        if (srst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
            r_vld <= 1'b0;
            r_arm <= 1'b0;
        end else begin
            r_s1 <= vsync_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            r_vld <= 1'b1;
            r_arm <= r_arm | (r_vld & ~r_s1);
        end
    end

    // State register
    always_ff @(posedge clk_sys or posedge srst) begin
        if (srst) r_state <= IDLE;
        else r_state <= w_next;
    end

    // Next-state logic plus render-start and missed-frame decisions
    always_comb begin
        w_next = r_state;
        w_start = 1'b0;
        w_miss = 1'b0;
        case (r_state)
            IDLE: begin
                w_next = en ? RENDER : IDLE;
                w_start = en;
            end
            RENDER: begin
                w_next = render_done ? (w_vs_rise ? SWAP : WAIT_VBL) : RENDER;
                w_miss = w_vs_rise & ~render_done;
            end
            WAIT_VBL: w_next = w_vs_rise ? SWAP : WAIT_VBL;
            SWAP: w_next = SETTLE;
            SETTLE: begin
                w_next = (r_settle != 8'd0) ? SETTLE : (en ? RENDER : IDLE);
                w_start = (r_settle == 8'd0) & en;
            end
            default: w_next = IDLE;
        endcase
    end

    // Registered pulses, buffer select, counters, sticky error and settle timer
    always_ff @(posedge clk_sys or posedge srst) begin
        if (srst) begin
            front_sel <= 1'b0;
            swap_tick <= 1'b0;
            render_start <= 1'b0;
            frame_cnt <= '0;
            miss_cnt <= '0;
            proto_err <= 1'b0;
            r_settle <= 8'd0;
        end else begin
            swap_tick <= (w_next == SWAP);
            render_start <= w_start;
            if (w_next == SWAP) begin
                front_sel <= ~front_sel;
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (w_miss && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            if (render_done && r_state != RENDER) proto_err <= 1'b1;
            if (r_state == SWAP) r_settle <= 8'(SETTLE_CYCLES - 1);
            else if (r_state == SETTLE && r_settle != 8'd0) r_settle <= r_settle - 8'd1;
        end
    end
endmodule

// File: tb/tb_frame_swap_ctrl.sv
// tb_frame_swap_ctrl: randomized frame sequences scored against an event-level model of swaps and render starts
module tb_frame_swap_ctrl;
    localparam int S = 4;
    localparam int W = 2;
    localparam int MAXC = (1 << W) - 1;

    logic clk_sys = 1'b0;
    logic srst = 1'b0;
    logic en = 1'b0;
    logic vsync_async = 1'b0;
    logic render_done = 1'b0;
    logic front_sel, swap_tick, render_start, proto_err;
    logic [W-1:0] frame_cnt, miss_cnt;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int m_front, m_fcnt, m_miss, m_perr;

    typedef struct {
        int kind;
        int cyc;
        int front;
        int fcnt;
        int mcnt;
        int perr;
    } ev_t;
    ev_t q[$];
    ev_t mon_e;

    frame_swap_ctrl #(.SETTLE_CYCLES(S), .CNT_W(W)) dut (
        .clk_sys(clk_sys),
        .srst(srst),
        .en(en),
        .vsync_async(vsync_async),
        .render_done(render_done),
        .front_sel(front_sel),
        .swap_tick(swap_tick),
        .render_start(render_start),
        .frame_cnt(frame_cnt),
        .miss_cnt(miss_cnt),
        .proto_err(proto_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // kind 1 = swap (updates buffer model first), kind 0 = render start
    task automatic push(input int kind, input int c);
        ev_t e;
        if (kind == 1) begin
            m_front ^= 1;
            m_fcnt = (m_fcnt + 1) % (MAXC + 1);
        end
        e.kind = kind;
        e.cyc = c;
        e.front = m_front;
        e.fcnt = m_fcnt;
        e.mcnt = m_miss;
        e.perr = m_perr;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic vs_pulse(input bit miss);
        vsync_async = 1'b1;
        repeat (3) tick();
        vsync_async = 1'b0;
        repeat (3) tick();
        if (miss && m_miss < MAXC) m_miss++;
    endtask

    task automatic model_reset();
        m_front = 0;
        m_fcnt = 0;
        m_miss = 0;
        m_perr = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_front_sel"}, int'(front_sel), 0);
        chk({tag, "_swap_tick"}, int'(swap_tick), 0);
        chk({tag, "_render_start"}, int'(render_start), 0);
        chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
        chk({tag, "_miss_cnt"}, int'(miss_cnt), 0);
        chk({tag, "_proto_err"}, int'(proto_err), 0);
    endtask

    // One frame starting in RENDER: optional misses, then a ready frame meeting a vsync
    task automatic frame();
        int mode, c;
        bit en_next;
        en_next = ($urandom_range(0, 3) != 0);
        mode = $urandom_range(0, 2);
        tick();
        en = en_next;
        repeat ($urandom_range(0, 3)) vs_pulse(1'b1);
        if (mode == 2) begin
            c = cyc + 3;
            push(1, c);
            if (en_next) push(0, c + S + 1);
            vsync_async = 1'b1;
            tick();
            tick();
            render_done = 1'b1;
            tick();
            render_done = 1'b0;
            vsync_async = 1'b0;
            repeat (3) tick();
        end else begin
            repeat ($urandom_range(1, 8)) tick();
            render_done = 1'b1;
            tick();
            render_done = 1'b0;
            if (mode == 1) begin
                tick();
                render_done = 1'b1;
                tick();
                render_done = 1'b0;
                m_perr = 1;
            end
            repeat ($urandom_range(0, 4)) tick();
            c = cyc + 3;
            push(1, c);
            if (en_next) push(0, c + S + 1);
            vs_pulse(1'b0);
        end
        repeat (4) tick();
        if (!en_next) begin
            if ($urandom_range(0, 1) != 0) begin
                vs_pulse(1'b0);
                render_done = 1'b1;
                tick();
                render_done = 1'b0;
                m_perr = 1;
            end
            en = 1'b1;
            push(0, cyc + 1);
            tick();
        end
    endtask

    // Monitor: every output pulse must match the oldest expected event
    always @(negedge clk_sys) begin
        if (!srst && (swap_tick || render_start)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: swap_tick=%0b render_start=%0b at cycle %0d, expected no pulse",
                         swap_tick, render_start, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("ev_kind", int'(swap_tick), mon_e.kind);
                chk("ev_cycle", cyc, mon_e.cyc);
                chk("ev_front_sel", int'(front_sel), mon_e.front);
                chk("ev_frame_cnt", int'(frame_cnt), mon_e.fcnt);
                chk("ev_miss_cnt", int'(miss_cnt), mon_e.mcnt);
                chk("ev_proto_err", int'(proto_err), mon_e.perr);
            end
        end
    end

    initial begin
        model_reset();
        #1 srst = 1'b1;
        #2;
        chk_reset("init");
        repeat (3) tick();
        srst = 1'b0;
        en = 1'b1;
        push(0, cyc + 1);
        for (int i = 0; i < 40; i++) frame();
        // Asynchronous reset landing in the SWAP cycle
        tick();
        render_done = 1'b1;
        tick();
        render_done = 1'b0;
        repeat (2) tick();
        vsync_async = 1'b1;
        tick();
        tick();
        @(posedge clk_sys);
        #1;
        chk("swap_before_reset", int'(swap_tick), 1);
        srst = 1'b1;
        #1;
        chk_reset("swap_reset");
        model_reset();
        repeat (3) tick();
        // vsync still high at release: it must not count as a rise
        srst = 1'b0;
        push(0, cyc + 1);
        tick();
        repeat (3) tick();
        render_done = 1'b1;
        tick();
        render_done = 1'b0;
        repeat (8) tick();
        vsync_async = 1'b0;
        repeat (3) tick();
        push(1, cyc + 3);
        push(0, cyc + 3 + S + 1);
        vs_pulse(1'b0);
        repeat (10) tick();
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
